// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline control blocks.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam logic [4:0] REG_ZERO          = 5'd0;
  localparam int         MD_CYCLES_DEFAULT = 32;

endpackage

// File: rtl/hazard_unit_md_sequencer.sv
// Multiply/divide occupancy sequencer: tracks the busy window of the iterative
// mult/div unit and pulses done when HI/LO should be latched.
module md_sequencer
  import mips_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic overrun
);

  localparam int CW = 6;

  md_state_t     state;
  logic [CW-1:0] count;

  assign busy = (state != IDLE);

  // A start seen while occupied is dropped but remembered in the sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= BUSY;
            count <= CW'(MD_CYCLES - 1);
          end
        end
        BUSY: begin
          if (count == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            count <= count - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (start && (state != IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard detection: load-use, branch-compare and mult/div stalls,
// taken-branch flush, and a saturating stall-cycle performance counter.
module hazard_unit
  import mips_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEFAULT,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       write_regE,
  input  logic [4:0]       write_regM,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             MdUseD,
  input  logic             MultDivStartE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             md_busy,
  output logic             md_done,
  output logic             md_overrun,
  output logic [CNT_W-1:0] stall_cycles
);

  logic matchE;
  logic matchM;
  logic lwStall;
  logic branchStall;
  logic mdStall;
  logic anyStall;

  md_sequencer #(
    .MD_CYCLES(MD_CYCLES)
  ) uSequencer (
    .clk    (clk),
    .rst    (rst),
    .start  (MultDivStartE),
    .busy   (md_busy),
    .done   (md_done),
    .overrun(md_overrun)
  );

  assign matchE = (write_regE != REG_ZERO) && ((write_regE == rsD) || (write_regE == rtD));
  assign matchM = (write_regM != REG_ZERO) && ((write_regM == rsD) || (write_regM == rtD));

  assign lwStall     = MemtoRegE && RegWriteE && matchE;
  assign branchStall = BranchD && ((RegWriteE && matchE) || (MemtoRegM && matchM));
  assign mdStall     = MdUseD && (md_busy || MultDivStartE);

  // Controls are held quiet during reset; a stall always wins over a branch flush.
  assign anyStall = !rst && (lwStall || branchStall || mdStall);
  assign StallF   = anyStall;
  assign StallD   = anyStall;
  assign FlushE   = anyStall;
  assign FlushD   = !rst && PCSrcD && !anyStall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (StallD && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
